// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// No logic; no latency.
// No flow control of its own.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int LAT_DEFAULT        = 4;
  localparam int STREAK_MAX_DEFAULT = 2;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and data requests with a starvation guard for fetch.
// Purely combinational, zero latency.
// Data wins unless it has already taken STREAK_MAX grants in a row while fetch waits.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STREAK_MAX = STREAK_MAX_DEFAULT
) (
  input  logic       i_d_req,
  input  logic       i_i_req,
  input  logic [1:0] i_d_streak,
  output logic       o_gnt_vld,
  output logic       o_gnt_d
);

  localparam logic [1:0] STREAK_LIM = 2'(STREAK_MAX);

  // Data has priority until its streak limit is reached with a fetch pending
  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt_d   = 1'b0;
    if (i_d_req && (!i_i_req || (i_d_streak < STREAK_LIM))) begin
      o_gnt_vld = 1'b1;
      o_gnt_d   = 1'b1;
    end else if (i_i_req) begin
      o_gnt_vld = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-ported memory between the fetch and memory stages.
// Request seen in IDLE at T: m_en at T+1, done pulse at T+2+LAT; LAT+3 cycles per access.
// Requesters hold req until done; stall = req & ~done gates their pipeline registers.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LAT        = LAT_DEFAULT,
  parameter int STREAK_MAX = STREAK_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_done,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        m_en,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  output logic        err
);

  localparam int              CW         = $clog2(LAT + 1);
  localparam logic [CW-1:0]   CNT_LOAD   = CW'(LAT - 1);
  localparam logic [1:0]      STREAK_LIM = 2'(STREAK_MAX);

  state_t        r_state;
  logic          r_owner;
  logic [15:0]   r_addr;
  logic          r_wr;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_d_streak;
  logic [15:0]   r_i_rdata;
  logic [15:0]   r_d_rdata;
  logic          r_i_done;
  logic          r_d_done;
  logic          r_err;
  logic          r_m_en;
  logic          r_m_wr;
  logic [15:0]   r_m_addr;
  logic [15:0]   r_m_wdata;

  logic          w_gnt_vld;
  logic          w_gnt_d;
  logic          w_gnt_wr;
  logic [15:0]   w_gnt_addr;
  logic          w_own_req;
  logic [15:0]   w_own_addr;
  logic          w_busy;
  logic          w_proto_err;

  mem_arb_prio #(
    .STREAK_MAX (STREAK_MAX)
  ) u_prio (
    .i_d_req    (d_req),
    .i_i_req    (i_req),
    .i_d_streak (r_d_streak),
    .o_gnt_vld  (w_gnt_vld),
    .o_gnt_d    (w_gnt_d)
  );

  // Fetch can never write, so the write flag only follows d_wr on a data grant
  assign w_gnt_wr   = w_gnt_d & d_wr;
  assign w_gnt_addr = w_gnt_d ? d_addr : i_addr;

  // Owner must keep its request and address stable while the access is in flight
  assign w_own_req   = (r_owner == OWNER_D) ? d_req  : i_req;
  assign w_own_addr  = (r_owner == OWNER_D) ? d_addr : i_addr;
  assign w_busy      = (r_state == ISSUE) || (r_state == WAIT);
  assign w_proto_err = w_busy && (!w_own_req || (w_own_addr != r_addr));

  // Arbitration FSM with latched access, latency counter and registered memory/done outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_owner    <= OWNER_I;
      r_addr     <= '0;
      r_wr       <= 1'b0;
      r_cnt      <= '0;
      r_d_streak <= '0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_i_done   <= 1'b0;
      r_d_done   <= 1'b0;
      r_err      <= 1'b0;
      r_m_en     <= 1'b0;
      r_m_wr     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
    end else begin
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_m_en    <= 1'b0;
      r_m_wr    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      if (w_proto_err) begin
        r_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_state   <= ISSUE;
            r_owner   <= w_gnt_d ? OWNER_D : OWNER_I;
            r_addr    <= w_gnt_addr;
            r_wr      <= w_gnt_wr;
            r_m_en    <= 1'b1;
            r_m_wr    <= w_gnt_wr;
            r_m_addr  <= w_gnt_addr;
            r_m_wdata <= w_gnt_d ? d_wdata : 16'h0000;
            // Streak only grows while fetch is actually being held off
            if (w_gnt_d && i_req) begin
              if (r_d_streak < STREAK_LIM) begin
                r_d_streak <= r_d_streak + 2'd1;
              end
            end else begin
              r_d_streak <= '0;
            end
          end
        end
        ISSUE: begin
          r_cnt   <= CNT_LOAD;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt == '0) begin
            if (!r_wr) begin
              if (r_owner == OWNER_D) begin
                r_d_rdata <= m_rdata;
              end else begin
                r_i_rdata <= m_rdata;
              end
            end
            if (r_owner == OWNER_D) begin
              r_d_done <= 1'b1;
            end else begin
              r_i_done <= 1'b1;
            end
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign i_rdata = r_i_rdata;
  assign i_done  = r_i_done;
  assign d_rdata = r_d_rdata;
  assign d_done  = r_d_done;
  assign m_en    = r_m_en;
  assign m_wr    = r_m_wr;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign err     = r_err;

  assign i_stall = i_req & ~r_i_done;
  assign d_stall = d_req & ~r_d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with LAT=4 and a latency-accurate memory model.
// Inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Expected values are hand-derived cycle numbers and data constants.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_done;
  logic        i_stall;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        d_stall;
  logic        m_en;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        err;

  int n_tests;
  int n_fail;

  mem_arbiter #(
    .LAT        (LAT),
    .STREAK_MAX (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_done  (i_done),
    .i_stall (i_stall),
    .d_req   (d_req),
    .d_wr    (d_wr),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_done  (d_done),
    .d_stall (d_stall),
    .m_en    (m_en),
    .m_wr    (m_wr),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: unwritten word k reads 0x1000+k, except 0x10 reads 0xBEEF.
  // Read data appears on m_rdata only in the single cycle LAT after m_en.
  logic        mem_clr;
  logic [15:0] wmem [0:255];
  logic        wvld [0:255];
  logic [15:0] rd_pipe [0:LAT-1];
  logic [7:0]  m_idx;
  logic [15:0] rd_val;

  assign m_idx   = m_addr[7:0];
  assign rd_val  = wvld[m_idx] ? wmem[m_idx] :
                   (m_idx == 8'h10) ? 16'hBEEF : (16'h1000 + {8'h00, m_idx});
  assign m_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 256; k++) begin
        wvld[k] <= 1'b0;
        wmem[k] <= 16'h0000;
      end
    end else if (m_en && m_wr) begin
      wvld[m_idx] <= 1'b1;
      wmem[m_idx] <= m_wdata;
    end
    rd_pipe[0] <= (m_en && !m_wr) ? rd_val : 16'h0000;
    for (int k = 1; k < LAT; k++) begin
      rd_pipe[k] <= rd_pipe[k-1];
    end
  end

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    d_wr  = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  // One isolated access starting at cycle 0; requester drops req at cycle 7
  task automatic single_access(input string tag, input logic is_d, input logic wr,
                               input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [15:0] exp_rd);
    if (is_d) begin
      d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int c = 0; c <= 7; c++) begin
      if (c == 7) begin
        d_req = 1'b0; i_req = 1'b0; d_wr = 1'b0;
      end
      #1;
      check({tag, "_m_en"}, 16'(m_en), 16'(c == 1));
      check({tag, "_done"}, 16'(is_d ? d_done : i_done), 16'(c == 6));
      check({tag, "_stall"}, 16'(is_d ? d_stall : i_stall), 16'(c <= 5));
      if (c == 1) begin
        check({tag, "_m_addr"}, m_addr, addr);
        check({tag, "_m_wr"}, 16'(m_wr), 16'(is_d & wr));
        check({tag, "_m_wdata"}, m_wdata, is_d ? wdata : 16'h0000);
      end
      if (c == 2) begin
        check({tag, "_m_addr_idle"}, m_addr, 16'h0000);
      end
      if (c >= 6) begin
        check({tag, "_rdata"}, is_d ? d_rdata : i_rdata, exp_rd);
      end
      next_cycle();
    end
  endtask

  logic [15:0] gaddr [0:5];
  logic [15:0] exp_g [0:5];
  int          ng;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    mem_clr = 1'b1;
    i_addr  = 16'h0000;
    d_addr  = 16'h0000;
    d_wdata = 16'h0000;
    do_reset();
    mem_clr = 1'b0;

    // Reset state
    check("rst_m_en", 16'(m_en), 16'h0000);
    check("rst_i_done", 16'(i_done), 16'h0000);
    check("rst_d_done", 16'(d_done), 16'h0000);
    check("rst_err", 16'(err), 16'h0000);
    check("rst_i_rdata", i_rdata, 16'h0000);
    check("rst_d_rdata", d_rdata, 16'h0000);

    // Single fetch from 0x0010
    single_access("fetch", 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

    // Simultaneous requests: D first, then I after returning to IDLE
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
    i_req = 1'b1; i_addr = 16'h0020;
    for (int c = 0; c <= 14; c++) begin
      if (c == 7)  d_req = 1'b0;
      if (c == 14) i_req = 1'b0;
      #1;
      check("sim_m_en", 16'(m_en), 16'((c == 1) || (c == 8)));
      check("sim_d_done", 16'(d_done), 16'(c == 6));
      check("sim_i_done", 16'(i_done), 16'(c == 13));
      check("sim_d_stall", 16'(d_stall), 16'(c <= 5));
      check("sim_i_stall", 16'(i_stall), 16'(c <= 12));
      if (c == 1)  check("sim_m_addr_d", m_addr, 16'h0200);
      if (c == 8)  check("sim_m_addr_i", m_addr, 16'h0020);
      if (c == 6)  check("sim_d_rdata", d_rdata, 16'h1000);
      if (c == 13) check("sim_i_rdata", i_rdata, 16'h1020);
      next_cycle();
    end

    // Starvation guard: both held, D moves to a new address after each d_done
    exp_g[0] = 16'h0040; exp_g[1] = 16'h0041; exp_g[2] = 16'h0030;
    exp_g[3] = 16'h0042; exp_g[4] = 16'h0043; exp_g[5] = 16'h0030;
    ng = 0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
    i_req = 1'b1; i_addr = 16'h0030;
    for (int c = 0; c <= 41; c++) begin
      #1;
      check("stv_m_en", 16'(m_en), 16'((c % 7) == 1));
      if (m_en) begin
        if (ng < 6) gaddr[ng] = m_addr;
        ng++;
      end
      if (d_done) d_addr = d_addr + 16'h0001;
      next_cycle();
    end
    d_req = 1'b0; i_req = 1'b0;
    check("stv_ngrants", 16'(ng), 16'd6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("stv_grant%0d", k), gaddr[k], exp_g[k]);
    end
    check("stv_err", 16'(err), 16'h0000);
    check("stv_d_rdata", d_rdata, 16'h1043);
    check("stv_i_rdata", i_rdata, 16'h1030);

    // Store: d_rdata keeps the last load value
    single_access("store", 1'b1, 1'b1, 16'h0100, 16'h1234, 16'h1043);

    // Reset in the middle of a load
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0005;
    for (int c = 0; c <= 10; c++) begin
      if (c == 3) begin rst = 1'b0; d_req = 1'b0; end
      if (c == 4) rst = 1'b1;
      #1;
      if (c == 1) check("rmid_m_en_pre", 16'(m_en), 16'h0001);
      if (c >= 4) begin
        check("rmid_m_en", 16'(m_en), 16'h0000);
        check("rmid_d_done", 16'(d_done), 16'h0000);
        check("rmid_d_rdata", d_rdata, 16'h0000);
        check("rmid_err", 16'(err), 16'h0000);
      end
      if (c == 4) begin
        check("rmid_i_rdata", i_rdata, 16'h0000);
        check("rmid_i_done", 16'(i_done), 16'h0000);
        check("rmid_stall", 16'({i_stall, d_stall}), 16'h0000);
        check("rmid_m_bus", m_addr | m_wdata | 16'(m_wr), 16'h0000);
      end
      next_cycle();
    end

    // Normal load after reset returns the earlier store
    single_access("load_after", 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h1234);

    // Owner drops d_req mid-access: err sticky, access still completes
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0007;
    for (int c = 0; c <= 9; c++) begin
      if (c == 3) d_req = 1'b0;
      #1;
      check("perr_err", 16'(err), 16'(c >= 4));
      check("perr_d_done", 16'(d_done), 16'(c == 6));
      if (c == 6) check("perr_d_rdata", d_rdata, 16'h1007);
      next_cycle();
    end
    check("perr_err_held", 16'(err), 16'h0001);
    do_reset();
    check("perr_err_clr", 16'(err), 16'h0000);

    // Owner changes its address mid-access: err, but the latched address completes
    i_req = 1'b1; i_addr = 16'h0010;
    for (int c = 0; c <= 7; c++) begin
      if (c == 2) i_addr = 16'h0011;
      if (c == 7) i_req = 1'b0;
      #1;
      check("aerr_err", 16'(err), 16'(c >= 3));
      check("aerr_i_done", 16'(i_done), 16'(c == 6));
      if (c == 6) check("aerr_i_rdata", i_rdata, 16'hBEEF);
      next_cycle();
    end
    do_reset();
    check("aerr_err_clr", 16'(err), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates between the fetch stage (instruction side) and the memory stage (data side) for one shared single-ported, fixed-latency 16-bit memory.
- Issues one access at a time and returns the read data to the requester that owns the access.
- Generates the per-side stall signals that gate the pipeline registers, in the same way Dmem_Stall gates them today.
- Sits between the fetch/memory stages and the unified memory model.

Parameters:
- LAT, 4: memory read latency in cycles. m_rdata is valid LAT cycles after the m_en cycle. Legal range is 1..15.
- STREAK_MAX, 2: maximum number of consecutive data-side grants while i_req is pending.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  synchronous active-low reset, sampled on the rising edge of clk (0 = reset)
- i_req  in  1  fetch request; level signal, held until i_done
- i_addr  in  16  fetch address
- i_rdata  out  16  fetched instruction; valid when i_done=1 and held afterwards
- i_done  out  1  one-cycle pulse: fetch access complete
- i_stall  out  1  fetch must hold
- d_req  in  1  data request; level signal, held until d_done
- d_wr  in  1  1 = write, 0 = read
- d_addr  in  16  data address
- d_wdata  in  16  write data
- d_rdata  out  16  load data; valid when d_done=1 and held afterwards
- d_done  out  1  one-cycle pulse: data access complete
- d_stall  out  1  memory stage must hold
- m_en  out  1  memory access strobe, exactly one cycle per access
- m_wr  out  1  memory write enable, qualified by m_en
- m_addr  out  16  memory address
- m_wdata  out  16  memory write data
- m_rdata  in  16  memory read data
- err  out  1  sticky protocol error

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE. Internal registers: owner (I/D), latched addr/wr/wdata, down-counter cnt of width $clog2(LAT+1), 2-bit d_streak.
- IDLE, grant rule:
  - If d_req=1, and either i_req=0 or d_streak<STREAK_MAX: grant D.
  - Else if i_req=1: grant I.
  - On a grant: latch owner, addr, wr, wdata; go to ISSUE.
- ISSUE (one cycle):
  - m_en=1; m_addr, m_wr and m_wdata driven from the latched values. m_wr is forced to 0 for the I owner.
  - cnt loads LAT-1; go to WAIT.
- WAIT:
  - When cnt==0, capture m_rdata into the owner's rdata register (reads only) and go to DONE.
  - Otherwise decrement cnt.
- DONE (one cycle):
  - The owner's done=1; go to IDLE. There is no back-to-back issue from DONE.
  - A D grant increments d_streak, saturating at STREAK_MAX.
  - An I grant, or a D grant with i_req=0, clears d_streak.
- Latency: request seen in IDLE at cycle T → m_en at T+1 → m_rdata sampled at T+1+LAT → done at T+2+LAT. Occupancy is LAT+3 cycles per access.
- m_en, m_wr, m_addr and m_wdata are 0 outside ISSUE.
- Stalls (combinational): i_stall = i_req & ~i_done; d_stall = d_req & ~d_done.
- Writes: d_rdata is unchanged and d_done still pulses.
- Non-owner requests are ignored until the FSM returns to IDLE.
- err is set to 1 and held until reset if, in ISSUE or WAIT, either of the following occurs:
  - the owner's req drops, or
  - the owner's addr differs from the latched addr.
  The access still completes and done still pulses.
- Reset (rst=0 at a clock edge):
  - All registers clear: state=IDLE; cnt, d_streak, i_rdata, d_rdata = 0; done, err, m_* = 0.
  - Any in-flight access is discarded, including a reset mid-WAIT.

Decomposition:
- Package mem_arb_pkg: the state enum (IDLE/ISSUE/WAIT/DONE), the OWNER_I/OWNER_D constants, and the default LAT and STREAK_MAX values.
- One sub-module, mem_arb_prio: combinational grant selection from d_req, i_req and d_streak.
- The FSM, counter and datapath registers stay in mem_arbiter.

Test Plan (all with LAT=4):
- Single fetch: i_req=1, i_addr=0x0010 at cycle 0; memory drives m_rdata=0xBEEF at cycle 5 → m_en=1 and m_addr=0x0010 at cycle 1; i_done=1 and i_rdata=0xBEEF at cycle 6; i_stall=1 during cycles 0–5.
- Simultaneous requests at cycle 0 (d_addr=0x0200, i_addr=0x0020) → D issued at cycle 1 with d_done at cycle 6; back in IDLE at cycle 7; I issued at cycle 8 with i_done at cycle 13.
- Starvation guard: d_req held high continuously with a new d_addr after each d_done, and i_req held high → grants D, D, I, D, D, I.
- Store: d_wr=1, d_addr=0x0100, d_wdata=0x1234 → m_en=1, m_wr=1, m_wdata=0x1234 at cycle 1; d_done at cycle 6; d_rdata keeps its prior value.
- Reset mid-access: rst=0 at cycle 3 → at cycle 4, state=IDLE and all outputs 0; no done pulse; a subsequent request then completes with normal timing.
- Protocol error: d_req dropped at cycle 3 → err=1 from cycle 4 and held; d_done still pulses at cycle 6; err clears only on rst=0.
